pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 15 +
 rtl/pc_gen_perf.sv | 43 ++++
 rtl/pc_gen.sv | 103 ++++++++++
 tb/tb_pc_gen.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-stage PC generator: next-PC operation codes
// and default address constants.
package pc_gen_pkg;

    typedef enum logic [2:0] {
        NPC_PlusFour = 3'd0,
        NPC_Jump     = 3'd1,
        NPC_JumpReg  = 3'd2,
        NPC_Branch   = 3'd3
    } npc_op_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_EXC_VEC  = 32'h0000_4180;

endpackage

// File: rtl/pc_gen_perf.sv
// Saturating 32-bit event counters for the PC generator (redirects, stall cycles).
// Only instantiated when PC_GEN_PERF_EN is defined.
module pc_gen_perf (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        redirect,
    input  logic        stall_only,
    output logic [31:0] redirect_cnt,
    output logic [31:0] stall_cnt
);

    logic [1:0]  inc;
    logic [31:0] cnt [2];

    assign inc = {stall_only, load & redirect};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [31:0] cnt_q;
        logic [31:0] cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (inc[gi] && (cnt_q != 32'hFFFF_FFFF)) begin
                cnt_d = cnt_q + 32'd1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign cnt[gi] = cnt_q;
    end

    assign redirect_cnt = cnt[0];
    assign stall_cnt    = cnt[1];

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: combinational next-PC select with exception/eret priority,
// stall hold, delay-slot tracking. Optional counters under macro PC_GEN_PERF_EN.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
    parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(DEFAULT_EXC_VEC),
    parameter logic [WIDTH-1:0] TEXT_LO  = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] TEXT_HI  = WIDTH'(32'h0000_6FFF),
    parameter logic [WIDTH-1:0] ERET_ADJ = WIDTH'(4)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Req,
    input  logic             eret_D,
    input  logic             stall,
    input  logic [2:0]       NPCOp,
    input  logic             BranchSignal,
    input  logic [WIDTH-1:0] PC_D,
    input  logic [31:0]      offset,
    input  logic [25:0]      Instr_index,
    input  logic [WIDTH-1:0] RegData,
    input  logic [WIDTH-1:0] EPCOut,
    output logic [WIDTH-1:0] PC_F,
    output logic [WIDTH-1:0] NPC,
    output logic             AdEL_F,
    output logic             BD_F,
    output logic             kill_F,
    output logic [31:0]      redirect_cnt,
    output logic [31:0]      stall_cnt
);

    logic [WIDTH-1:0] pc_f_q, pc_f_d;
    logic             bd_f_q, bd_f_d;
    logic [WIDTH-1:0] pc_plus4, branch_tgt, jump_tgt, npc;
    logic             load;

    assign pc_plus4   = pc_f_q + WIDTH'(4);
    assign branch_tgt = PC_D + WIDTH'(4) + (WIDTH'(signed'(offset)) << 2);
    assign jump_tgt   = {PC_D[WIDTH-1:28], Instr_index, 2'b00};

    always_comb begin
        npc = pc_plus4;
        if (Req) begin
            npc = EXC_VEC;
        end else if (eret_D) begin
            npc = EPCOut + ERET_ADJ;
        end else begin
            case (NPCOp)
                NPC_Jump:    npc = jump_tgt;
                NPC_JumpReg: npc = RegData;
                NPC_Branch:  npc = BranchSignal ? branch_tgt : pc_plus4;
                default:     npc = pc_plus4;
            endcase
        end
    end

    // An exception must be taken even while the pipeline front end is stalled.
    assign load = Req | ~stall;

    always_comb begin
        pc_f_d = pc_f_q;
        bd_f_d = bd_f_q;
        if (load) begin
            pc_f_d = npc;
            bd_f_d = (NPCOp != NPC_PlusFour) & ~Req & ~eret_D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q <= RESET_PC;
            bd_f_q <= 1'b0;
        end else begin
            pc_f_q <= pc_f_d;
            bd_f_q <= bd_f_d;
        end
    end

    assign PC_F   = pc_f_q;
    assign NPC    = npc;
    assign BD_F   = bd_f_q;
    assign AdEL_F = (pc_f_q[1:0] != 2'b00) | (pc_f_q < TEXT_LO) | (pc_f_q > TEXT_HI);
    // eret has no delay slot, so whatever was fetched behind it is dropped.
    assign kill_F = eret_D & ~stall & ~Req;

`ifdef PC_GEN_PERF_EN
    pc_gen_perf u_perf (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .redirect     (npc != pc_plus4),
        .stall_only   (stall & ~Req),
        .redirect_cnt (redirect_cnt),
        .stall_cnt    (stall_cnt)
    );
`else
    assign redirect_cnt = '0;
    assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: table of vectors with a scoreboard of expected
// fetch state, plus hand sequences for reset-during-redirect and the counters.
module tb_pc_gen;
    import pc_gen_pkg::*;

    logic        clk = 1'b0;
    logic        reset, Req, eret_D, stall, BranchSignal;
    logic [2:0]  NPCOp;
    logic [31:0] PC_D, offset, RegData, EPCOut;
    logic [25:0] Instr_index;
    logic [31:0] PC_F, NPC, redirect_cnt, stall_cnt;
    logic        AdEL_F, BD_F, kill_F;

    pc_gen dut (
        .clk(clk), .reset(reset), .Req(Req), .eret_D(eret_D), .stall(stall),
        .NPCOp(NPCOp), .BranchSignal(BranchSignal), .PC_D(PC_D), .offset(offset),
        .Instr_index(Instr_index), .RegData(RegData), .EPCOut(EPCOut),
        .PC_F(PC_F), .NPC(NPC), .AdEL_F(AdEL_F), .BD_F(BD_F), .kill_F(kill_F),
        .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req, eret, stall;
        logic [2:0]  op;
        logic        bsig;
        logic [31:0] pc_d, off;
        logic [25:0] idx;
        logic [31:0] rd, epc;
        logic [31:0] e_npc;
        logic        e_kill;
        logic [31:0] e_pc;
        logic        e_bd, e_adel;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        bd, adel;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

`ifdef PC_GEN_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic req, eret, stl, input logic [2:0] op,
                                input logic bsig, input logic [31:0] pc_d, off,
                                input logic [25:0] idx, input logic [31:0] rd, epc,
                                input logic [31:0] e_npc, input logic e_kill,
                                input logic [31:0] e_pc, input logic e_bd, e_adel);
        vec_t v;
        v.req = req; v.eret = eret; v.stall = stl; v.op = op; v.bsig = bsig;
        v.pc_d = pc_d; v.off = off; v.idx = idx; v.rd = rd; v.epc = epc;
        v.e_npc = e_npc; v.e_kill = e_kill; v.e_pc = e_pc; v.e_bd = e_bd; v.e_adel = e_adel;
        return v;
    endfunction

    // Drive one vector, check combinational outputs mid-cycle, then check fetch state after the edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        Req = v.req; eret_D = v.eret; stall = v.stall; NPCOp = v.op; BranchSignal = v.bsig;
        PC_D = v.pc_d; offset = v.off; Instr_index = v.idx; RegData = v.rd; EPCOut = v.epc;
        sb.push_back('{v.e_pc, v.e_bd, v.e_adel});
        @(negedge clk);
        chk({tag, " npc"}, NPC, v.e_npc);
        chk({tag, " kill_F"}, 32'(kill_F), 32'(v.e_kill));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL %s scoreboard: got empty expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, " pc_f"}, PC_F, e.pc);
            chk({tag, " bd_f"}, 32'(BD_F), 32'(e.bd));
            chk({tag, " adel_f"}, 32'(AdEL_F), 32'(e.adel));
        end
        $display("[TB] %s: pc_f=%h bd_f=%b adel_f=%b npc_was=%h", tag, PC_F, BD_F, AdEL_F, v.e_npc);
    endtask

    initial begin
        //                req eret stl op    bsig pc_d          off            idx        rd             epc             npc            kill pc             bd adel
        tbl.push_back(mk(0, 0, 0, 3'd0, 0, 32'h0,       32'h0,         26'h0,     32'h0,         32'h0,          32'h3004,      0, 32'h3004,      0, 0));
        tbl.push_back(mk(0, 0, 0, 3'd0, 0, 32'h0,       32'h0,         26'h0,     32'h0,         32'h0,          32'h3008,      0, 32'h3008,      0, 0));
        tbl.push_back(mk(0, 0, 0, 3'd0, 0, 32'h0,       32'h0,         26'h0,     32'h0,         32'h0,          32'h300C,      0, 32'h300C,      0, 0));
        tbl.push_back(mk(0, 0, 0, 3'd3, 1, 32'h3008,    32'hFFFF_FFFE, 26'h0,     32'h0,         32'h0,          32'h3004,      0, 32'h3004,      1, 0));
        tbl.push_back(mk(0, 0, 0, 3'd3, 0, 32'h3008,    32'hFFFF_FFFE, 26'h0,     32'h0,         32'h0,          32'h3008,      0, 32'h3008,      1, 0));
        tbl.push_back(mk(0, 0, 0, 3'd0, 0, 32'h0,       32'h0,         26'h0,     32'h0,         32'h0,          32'h300C,      0, 32'h300C,      0, 0));
        tbl.push_back(mk(0, 0, 0, 3'd0, 0, 32'h0,       32'h0,         26'h0,     32'h0,         32'h0,          32'h3010,      0, 32'h3010,      0, 0));
        tbl.push_back(mk(1, 0, 1, 3'd0, 0, 32'h0,       32'h0,         26'h0,     32'h0,         32'h0,          32'h4180,      0, 32'h4180,      0, 0));
        tbl.push_back(mk(0, 1, 0, 3'd0, 0, 32'h0,       32'h0,         26'h0,     32'h0,         32'h3020,       32'h3024,      1, 32'h3024,      0, 0));
        tbl.push_back(mk(0, 1, 1, 3'd0, 0, 32'h0,       32'h0,         26'h0,     32'h0,         32'h3020,       32'h3024,      0, 32'h3024,      0, 0));
        tbl.push_back(mk(0, 0, 0, 3'd2, 0, 32'h0,       32'h0,         26'h0,     32'h3001,      32'h0,          32'h3001,      0, 32'h3001,      1, 1));
        tbl.push_back(mk(0, 0, 0, 3'd2, 0, 32'h0,       32'h0,         26'h0,     32'h7000,      32'h0,          32'h7000,      0, 32'h7000,      1, 1));
        tbl.push_back(mk(0, 0, 0, 3'd1, 0, 32'h3010,    32'h0,         26'hC10,   32'h0,         32'h0,          32'h3040,      0, 32'h3040,      1, 0));
        tbl.push_back(mk(0, 0, 1, 3'd1, 0, 32'h3010,    32'h0,         26'hC10,   32'h0,         32'h0,          32'h3040,      0, 32'h3040,      1, 0));
        tbl.push_back(mk(0, 0, 1, 3'd0, 0, 32'h0,       32'h0,         26'h0,     32'h0,         32'h0,          32'h3044,      0, 32'h3040,      1, 0));
        tbl.push_back(mk(0, 0, 1, 3'd3, 1, 32'h3008,    32'hFFFF_FFFE, 26'h0,     32'h0,         32'h0,          32'h3004,      0, 32'h3040,      1, 0));
        tbl.push_back(mk(0, 0, 0, 3'd2, 0, 32'h0,       32'h0,         26'h0,     32'hFFFF_FFFC, 32'h0,          32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1, 1));
        tbl.push_back(mk(0, 0, 0, 3'd0, 0, 32'h0,       32'h0,         26'h0,     32'h0,         32'h0,          32'h0,         0, 32'h0,         0, 1));
        tbl.push_back(mk(1, 0, 0, 3'd0, 0, 32'h0,       32'h0,         26'h0,     32'h0,         32'h0,          32'h4180,      0, 32'h4180,      0, 0));
        tbl.push_back(mk(0, 0, 0, 3'd5, 0, 32'h0,       32'h0,         26'h0,     32'h0,         32'h0,          32'h4184,      0, 32'h4184,      1, 0));
        tbl.push_back(mk(1, 1, 0, 3'd1, 0, 32'h3010,    32'h0,         26'hC10,   32'h0,         32'h3020,       32'h4180,      0, 32'h4180,      0, 0));
        tbl.push_back(mk(0, 0, 0, 3'd2, 0, 32'h0,       32'h0,         26'h0,     32'h6FFC,      32'h0,          32'h6FFC,      0, 32'h6FFC,      1, 0));
        tbl.push_back(mk(0, 0, 0, 3'd0, 0, 32'h0,       32'h0,         26'h0,     32'h0,         32'h0,          32'h7000,      0, 32'h7000,      0, 1));

        reset = 1'b1; Req = 1'b1; eret_D = 1'b0; stall = 1'b1; NPCOp = 3'd1; BranchSignal = 1'b0;
        PC_D = '0; offset = '0; Instr_index = 26'hC10; RegData = '0; EPCOut = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset pc_f", PC_F, 32'h3000);
        chk("reset bd_f", 32'(BD_F), 32'd0);
        chk("reset adel_f", 32'(AdEL_F), 32'd0);
        chk("reset redirect_cnt", redirect_cnt, 32'd0);
        chk("reset stall_cnt", stall_cnt, 32'd0);
        $display("[TB] reset: pc_f=%h bd_f=%b", PC_F, BD_F);
        reset = 1'b0;

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Reset arriving with a jump pending must win; fetch restarts at RESET_PC.
        reset = 1'b1; Req = 1'b0; eret_D = 1'b0; stall = 1'b0; NPCOp = 3'd1;
        PC_D = 32'h3010; Instr_index = 26'hC10;
        @(posedge clk);
        #1;
        chk("midreset pc_f", PC_F, 32'h3000);
        chk("midreset bd_f", 32'(BD_F), 32'd0);
        $display("[TB] mid-redirect reset: pc_f=%h bd_f=%b", PC_F, BD_F);
        reset = 1'b0;

        apply(mk(0, 0, 0, 3'd1, 0, 32'h3000, 32'h0, 26'hC10, 32'h0, 32'h0, 32'h3040, 0, 32'h3040, 1, 0), "cnt_j1");
        apply(mk(0, 0, 0, 3'd1, 0, 32'h3000, 32'h0, 26'hC20, 32'h0, 32'h0, 32'h3080, 0, 32'h3080, 1, 0), "cnt_j2");
        for (int k = 0; k < 5; k++) begin
            apply(mk(0, 0, 1, 3'd0, 0, 32'h0, 32'h0, 26'h0, 32'h0, 32'h0, 32'h3084, 0, 32'h3080, 1, 0),
                  $sformatf("cnt_stall%0d", k));
        end
        chk("perf redirect_cnt", redirect_cnt, PERF ? 32'd2 : 32'd0);
        chk("perf stall_cnt", stall_cnt, PERF ? 32'd5 : 32'd0);
        apply(mk(1, 0, 1, 3'd0, 0, 32'h0, 32'h0, 26'h0, 32'h0, 32'h0, 32'h4180, 0, 32'h4180, 0, 0), "cnt_req_stall");
        chk("perf stall_cnt after req", stall_cnt, PERF ? 32'd5 : 32'd0);
        chk("perf redirect_cnt after req", redirect_cnt, PERF ? 32'd3 : 32'd0);
        $display("[TB] counters: redirect_cnt=%0d stall_cnt=%0d", redirect_cnt, stall_cnt);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
